// File: rtl/hls_accel_launcher.sv
// hls_accel_launcher: preloads a Bambu accelerator's memory over its slave RAM port,
// pulses start_port, times the run until done_port, reads results back and streams them
// out. Optional macro LAUNCHER_CHECKSUM_EN adds a running XOR of delivered result words.
module hls_accel_launcher #(
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned CYC_W      = 32,
    parameter int unsigned MAX_CYCLES = 200000000,
    parameter int unsigned RD_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_go,
    input  logic [ADDR_W-1:0] cfg_wr_base,
    input  logic [ADDR_W-1:0] cfg_rd_base,
    input  logic [CNT_W-1:0]  cfg_wr_count,
    input  logic [CNT_W-1:0]  cfg_rd_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              S_oe_ram,
    output logic              S_we_ram,
    output logic [ADDR_W-1:0] S_addr_ram,
    output logic [DATA_W-1:0] S_Wdata_ram,
    output logic [7:0]        S_data_ram_size,
    output logic              start_port,
    input  logic              done_port,
    input  logic [DATA_W-1:0] Sout_Rdata_ram,
    input  logic              Sout_DataRdy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              finished,
    output logic [CYC_W-1:0]  cyc_count,
    output logic [1:0]        err
`ifdef LAUNCHER_CHECKSUM_EN
    , output logic [DATA_W-1:0] checksum
`endif
);

    localparam int unsigned WAIT_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StRun, StRdReq, StRdWait, StDrain, StFin
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  wr_left_q, wr_left_d, rd_left_q, rd_left_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [1:0]        err_q, err_d;
`ifdef LAUNCHER_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;
`endif

    // State and job registers; reset abandons any job in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_left_q <= '0;
            rd_left_q <= '0;
            wait_q    <= '0;
            data_q    <= '0;
            cyc_q     <= '0;
            err_q     <= '0;
`ifdef LAUNCHER_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_left_q <= wr_left_d;
            rd_left_q <= rd_left_d;
            wait_q    <= wait_d;
            data_q    <= data_d;
            cyc_q     <= cyc_d;
            err_q     <= err_d;
`ifdef LAUNCHER_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    // Next-state logic and slave/stream outputs.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_left_d   = wr_left_q;
        rd_left_d   = rd_left_q;
        wait_d      = wait_q;
        data_d      = data_q;
        cyc_d       = cyc_q;
        err_d       = err_q;
`ifdef LAUNCHER_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        in_ready    = 1'b0;
        S_we_ram    = 1'b0;
        S_oe_ram    = 1'b0;
        S_addr_ram  = '0;
        S_Wdata_ram = '0;
        start_port  = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        finished    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cfg_go) begin
                    wr_addr_d = cfg_wr_base;
                    rd_addr_d = cfg_rd_base;
                    wr_left_d = cfg_wr_count;
                    rd_left_d = cfg_rd_count;
                    cyc_d     = '0;
                    err_d     = '0;
`ifdef LAUNCHER_CHECKSUM_EN
                    chk_d     = '0;
`endif
                    state_d   = (cfg_wr_count == '0) ? StStart : StLoad;
                end
            end
            StLoad: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Slave takes one write per cycle, so the handshake is the write.
                    S_we_ram    = 1'b1;
                    S_addr_ram  = wr_addr_q;
                    S_Wdata_ram = in_data;
                    wr_addr_d   = wr_addr_q + BYTES;
                    wr_left_d   = wr_left_q - 1'b1;
                    if (wr_left_q == CNT_W'(1)) state_d = StStart;
                end
            end
            StStart: begin
                start_port = 1'b1;
                cyc_d      = CYC_W'(1);
                if (done_port) state_d = (rd_left_q == '0) ? StFin : StRdReq;
                else           state_d = StRun;
            end
            StRun: begin
                cyc_d = cyc_q + 1'b1;
                // done_port wins over a timeout landing on the same cycle.
                if (done_port) begin
                    state_d = (rd_left_q == '0) ? StFin : StRdReq;
                end else if (cyc_d >= CYC_W'(MAX_CYCLES)) begin
                    err_d[0] = 1'b1;
                    state_d  = StFin;
                end
            end
            StRdReq: begin
                S_oe_ram   = 1'b1;
                S_addr_ram = rd_addr_q;
                rd_addr_d  = rd_addr_q + BYTES;
                wait_d     = '0;
                if (Sout_DataRdy) begin
                    data_d  = Sout_Rdata_ram;
                    state_d = StDrain;
                end else begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (Sout_DataRdy) begin
                    data_d  = Sout_Rdata_ram;
                    state_d = StDrain;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_d == WAIT_W'(RD_TIMEOUT)) begin
                        err_d[1] = 1'b1;
                        state_d  = StFin;
                    end
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                out_data  = data_q;
                if (out_ready) begin
`ifdef LAUNCHER_CHECKSUM_EN
                    chk_d = chk_q ^ data_q;
`endif
                    rd_left_d = rd_left_q - 1'b1;
                    state_d   = (rd_left_q == CNT_W'(1)) ? StFin : StRdReq;
                end
            end
            StFin: begin
                finished = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Status outputs.
    assign S_data_ram_size = (S_oe_ram || S_we_ram) ? 8'(DATA_W) : 8'd0;
    assign busy            = (state_q != StIdle);
    assign cyc_count       = cyc_q;
    assign err             = err_q;
`ifdef LAUNCHER_CHECKSUM_EN
    assign checksum        = chk_q;
`endif

endmodule

// File: tb/tb_hls_accel_launcher.sv
// Testbench for hls_accel_launcher: accelerator and slave-RAM stubs, a cycle monitor,
// and randomized jobs checked against a job-level reference model.
module tb_hls_accel_launcher;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int CYC_W  = 32;
    localparam int MAXC   = 50;
    localparam int RDTO   = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              cfg_go;
    logic [ADDR_W-1:0] cfg_wr_base, cfg_rd_base;
    logic [CNT_W-1:0]  cfg_wr_count, cfg_rd_count;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              S_oe_ram, S_we_ram;
    logic [ADDR_W-1:0] S_addr_ram;
    logic [DATA_W-1:0] S_Wdata_ram;
    logic [7:0]        S_data_ram_size;
    logic              start_port, done_port;
    logic [DATA_W-1:0] Sout_Rdata_ram;
    logic              Sout_DataRdy;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy, finished;
    logic [CYC_W-1:0]  cyc_count;
    logic [1:0]        err;
`ifdef LAUNCHER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    always #5 clock = ~clock;

    hls_accel_launcher #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .CYC_W(CYC_W),
        .MAX_CYCLES(MAXC), .RD_TIMEOUT(RDTO)
    ) dut (
        .clock(clock), .reset(reset), .cfg_go(cfg_go),
        .cfg_wr_base(cfg_wr_base), .cfg_rd_base(cfg_rd_base),
        .cfg_wr_count(cfg_wr_count), .cfg_rd_count(cfg_rd_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .start_port(start_port), .done_port(done_port),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .finished(finished), .cyc_count(cyc_count), .err(err)
`ifdef LAUNCHER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    // Accelerator stub: done_port fires done_delay cycles after start_port (0 = same
    // cycle, negative = never).
    int   done_delay = -1;
    int   done_cnt   = 0;
    logic done_r     = 1'b0;
    logic spur_done  = 1'b0;
    assign done_port = done_r | spur_done | ((done_delay == 0) & start_port);

    always @(negedge clock) begin
        if (start_port && done_delay > 0) begin
            done_cnt <= done_delay;
            done_r   <= 1'b0;
        end else if (done_cnt > 1) begin
            done_cnt <= done_cnt - 1;
            done_r   <= 1'b0;
        end else if (done_cnt == 1) begin
            done_cnt <= 0;
            done_r   <= 1'b1;
        end else begin
            done_r   <= 1'b0;
        end
    end

    // Slave read stub: rd_lat 0 answers combinationally, >0 answers later, <0 never.
    logic [DATA_W-1:0] rd_mem [0:(1<<ADDR_W)-1];
    int                rd_lat  = 0;
    int                pend    = 0;
    logic [ADDR_W-1:0] paddr   = '0;
    logic              rdy_q   = 1'b0;
    logic [DATA_W-1:0] rdata_q = '0;
    assign Sout_DataRdy   = ((rd_lat == 0) & S_oe_ram) | rdy_q;
    assign Sout_Rdata_ram = (rd_lat == 0) ? rd_mem[S_addr_ram] : rdata_q;

    always @(posedge clock) begin
        rdy_q <= 1'b0;
        if (S_oe_ram && rd_lat > 0) begin
            pend  <= rd_lat;
            paddr <= S_addr_ram;
        end else if (pend > 1) begin
            pend <= pend - 1;
        end else if (pend == 1) begin
            pend    <= 0;
            rdy_q   <= 1'b1;
            rdata_q <= rd_mem[paddr];
        end
    end

    // Cycle monitor: records what the DUT did, sampled just before each rising edge.
    logic              mon_clr = 1'b0;
    int                cyc_i = 0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [DATA_W-1:0] wd_q[$];
    logic [ADDR_W-1:0] oa_q[$];
    logic [DATA_W-1:0] od_q[$];
    int start_cnt, start_cyc, last_we_cyc, oe_cnt, last_oe_cyc, fin_cnt, fin_cyc;
    int stab_bad, stall_cycles, ov_bad, size_bad, go_cyc;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;

    always begin
        @(negedge clock);
        #4;
        if (mon_clr) begin
            wa_q.delete(); wd_q.delete(); oa_q.delete(); od_q.delete();
            start_cnt = 0; start_cyc = -1; last_we_cyc = -1; oe_cnt = 0; last_oe_cyc = -1;
            fin_cnt = 0; fin_cyc = -1; stab_bad = 0; stall_cycles = 0; ov_bad = 0;
            size_bad = 0; go_cyc = cyc_i;
        end
        if (S_we_ram) begin
            wa_q.push_back(S_addr_ram);
            wd_q.push_back(S_Wdata_ram);
            last_we_cyc = cyc_i;
        end
        if (start_port) begin
            start_cnt++;
            start_cyc = cyc_i;
        end
        if (S_oe_ram) begin
            oa_q.push_back(S_addr_ram);
            oe_cnt++;
            last_oe_cyc = cyc_i;
            if (out_valid) ov_bad++;
        end
        if (S_data_ram_size !== ((S_oe_ram || S_we_ram) ? 8'd8 : 8'd0)) size_bad++;
        if (out_valid) begin
            if (prev_stall && out_data !== prev_data) stab_bad++;
            if (out_ready) od_q.push_back(out_data);
            else stall_cycles++;
            prev_stall = !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
        if (finished) begin
            fin_cnt++;
            fin_cyc = cyc_i;
        end
        cyc_i++;
    end

    // Preload words for the next job, consumed by run_job.
    logic [DATA_W-1:0] wdat_q[$];

    // Job-level reference: timing and error outcome from the launch parameters.
    function automatic void model_job(input int dd, input int rl, input int rdc,
                                      output int exp_cyc, output logic [1:0] exp_err,
                                      output int exp_nout, output int exp_noe);
        bit run_to, rd_to;
        run_to   = (dd < 0) || (dd + 1 > MAXC);
        rd_to    = !run_to && (rdc > 0) && (rl < 0);
        exp_cyc  = run_to ? MAXC : dd + 1;
        exp_err  = {rd_to, run_to};
        exp_nout = (run_to || rd_to) ? 0 : rdc;
        exp_noe  = run_to ? 0 : (rd_to ? 1 : rdc);
    endfunction

    // Drives one job until finished or the cycle budget runs out.
    task automatic run_job(input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] rb,
                           input int wrc, input int rdc, input int dd, input int rl,
                           input int rpct, input bit stall5, input bit go_mid,
                           output bit ok);
        int  idx;
        int  n;
        int  stall_left;
        bit  v;
        @(negedge clock);
        done_delay   = dd;
        rd_lat       = rl;
        cfg_wr_base  = wb;
        cfg_rd_base  = rb;
        cfg_wr_count = CNT_W'(wrc);
        cfg_rd_count = CNT_W'(rdc);
        cfg_go       = 1'b1;
        mon_clr      = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        @(negedge clock);
        cfg_go     = 1'b0;
        mon_clr    = 1'b0;
        idx        = 0;
        n          = 0;
        stall_left = stall5 ? 5 : 0;
        while (fin_cnt == 0 && n < 600) begin
            v        = (idx < wrc) && ($urandom_range(0, 3) != 0);
            in_valid = v;
            in_data  = v ? wdat_q[idx] : DATA_W'($urandom);
            if (v && in_ready) idx++;
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 99) < rpct);
            end
            if (go_mid && n == 3) begin
                cfg_go       = 1'b1;
                cfg_wr_count = 16'd7;
                cfg_rd_count = 16'd9;
                cfg_wr_base  = '0;
            end else begin
                cfg_go = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cfg_go    = 1'b0;
        ok        = (fin_cnt != 0);
    endtask

    task automatic test_reset();
        reset = 1'b0; cfg_go = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_data = 8'h5C; cfg_wr_base = '0; cfg_rd_base = '0;
        cfg_wr_count = 16'd1; cfg_rd_count = 16'd1;
        repeat (3) @(negedge clock);
        n_total++; if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_total++; if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        n_total++; if ({S_we_ram, S_oe_ram, start_port, out_valid, finished} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl got=%b exp=00000",
                              {S_we_ram, S_oe_ram, start_port, out_valid, finished}); end
        n_total++; if (cyc_count !== 32'd0 || err !== 2'b00) begin
            n_bad++; $display("FAIL reset_status got=%0d/%b exp=0/00", cyc_count, err); end
        n_total++; if (S_data_ram_size !== 8'd0 || S_addr_ram !== '0) begin
            n_bad++; $display("FAIL reset_slave got=%0d/%h exp=0/0", S_data_ram_size,
                              S_addr_ram); end
        in_valid = 1'b0; out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        bit ok;
        wdat_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        rd_mem[14'h200] = 8'hA5;
        rd_mem[14'h201] = 8'h5A;
        run_job(14'h100, 14'h200, 4, 2, 10, 1, 100, 1'b0, 1'b0, ok);
        n_total++; if (!ok) begin n_bad++; $display("FAIL basic_finish got=timeout exp=done"); end
        n_total++; if (wa_q.size() != 4) begin
            n_bad++; $display("FAIL basic_nwr got=%0d exp=4", wa_q.size()); end
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            n_total++;
            if (wa_q[i] !== 14'h100 + 14'(i) || wd_q[i] !== wdat_q[i]) begin
                n_bad++; $display("FAIL basic_wr%0d got=%h:%h exp=%h:%h", i, wa_q[i], wd_q[i],
                                  14'h100 + 14'(i), wdat_q[i]); end
        end
        n_total++; if (start_cnt != 1 || start_cyc != last_we_cyc + 1) begin
            n_bad++; $display("FAIL basic_start got=cnt%0d@%0d exp=cnt1@%0d", start_cnt,
                              start_cyc, last_we_cyc + 1); end
        n_total++; if (od_q.size() != 2) begin
            n_bad++; $display("FAIL basic_nout got=%0d exp=2", od_q.size()); end
        else if (od_q[0] !== 8'hA5 || od_q[1] !== 8'h5A) begin
            n_bad++; $display("FAIL basic_out got=%h,%h exp=a5,5a", od_q[0], od_q[1]); end
        n_total++; if (oe_cnt != 2 || oa_q[0] !== 14'h200 || oa_q[1] !== 14'h201) begin
            n_bad++; $display("FAIL basic_oe got=%0d oe exp=2 at 200,201", oe_cnt); end
        n_total++; if (cyc_count !== 32'd11 || err !== 2'b00) begin
            n_bad++; $display("FAIL basic_cyc got=%0d/%b exp=11/00", cyc_count, err); end
        repeat (3) @(negedge clock);
        n_total++; if (fin_cnt != 1 || busy !== 1'b0 || cyc_count !== 32'd11) begin
            n_bad++; $display("FAIL basic_hold got=fin%0d busy%0b cyc%0d exp=fin1 busy0 cyc11",
                              fin_cnt, busy, cyc_count); end
    endtask

    task automatic test_drain_stall();
        bit ok;
        logic [DATA_W-1:0] e[3];
        wdat_q = {};
        for (int j = 0; j < 3; j++) begin
            e[j] = DATA_W'($urandom);
            rd_mem[14'h040 + 14'(j)] = e[j];
        end
        run_job(14'h000, 14'h040, 0, 3, 2, 0, 100, 1'b1, 1'b0, ok);
        n_total++; if (!ok) begin n_bad++; $display("FAIL stall_finish got=timeout exp=done"); end
        n_total++; if (stall_cycles != 5 || stab_bad != 0) begin
            n_bad++; $display("FAIL stall_stable got=stall%0d unstable%0d exp=stall5 unstable0",
                              stall_cycles, stab_bad); end
        n_total++; if (ov_bad != 0 || oe_cnt != 3) begin
            n_bad++; $display("FAIL stall_oe got=overlap%0d oe%0d exp=overlap0 oe3", ov_bad,
                              oe_cnt); end
        n_total++; if (od_q.size() != 3 || od_q[0] !== e[0] || od_q[1] !== e[1] ||
                       od_q[2] !== e[2]) begin
            n_bad++; $display("FAIL stall_out got=%0d words exp=%h,%h,%h", od_q.size(), e[0],
                              e[1], e[2]); end
    endtask

    task automatic test_run_timeout();
        bit ok;
        wdat_q = '{8'h01, 8'h02};
        run_job(14'h010, 14'h020, 2, 2, -1, 0, 100, 1'b0, 1'b0, ok);
        n_total++; if (!ok) begin n_bad++; $display("FAIL runto_finish got=timeout exp=done"); end
        n_total++; if (err !== 2'b01 || cyc_count !== 32'(MAXC)) begin
            n_bad++; $display("FAIL runto_err got=%b/%0d exp=01/%0d", err, cyc_count, MAXC); end
        n_total++; if (oe_cnt != 0 || od_q.size() != 0) begin
            n_bad++; $display("FAIL runto_noread got=oe%0d out%0d exp=0/0", oe_cnt,
                              od_q.size()); end
        n_total++; if (fin_cyc != start_cyc + MAXC || fin_cnt != 1) begin
            n_bad++; $display("FAIL runto_fin got=+%0d x%0d exp=+%0d x1", fin_cyc - start_cyc,
                              fin_cnt, MAXC); end
    endtask

    task automatic test_read_timeout();
        bit ok;
        wdat_q = {};
        run_job(14'h000, 14'h300, 0, 2, 5, -1, 100, 1'b0, 1'b0, ok);
        n_total++; if (!ok) begin n_bad++; $display("FAIL rdto_finish got=timeout exp=done"); end
        n_total++; if (err !== 2'b10 || cyc_count !== 32'd6) begin
            n_bad++; $display("FAIL rdto_err got=%b/%0d exp=10/6", err, cyc_count); end
        n_total++; if (oe_cnt != 1 || od_q.size() != 0) begin
            n_bad++; $display("FAIL rdto_oe got=oe%0d out%0d exp=1/0", oe_cnt, od_q.size()); end
        n_total++; if (fin_cyc != last_oe_cyc + RDTO + 1) begin
            n_bad++; $display("FAIL rdto_wait got=+%0d exp=+%0d", fin_cyc - last_oe_cyc,
                              RDTO + 1); end
    endtask

    task automatic test_random_jobs();
        bit                ok;
        int                wrc, rdc, dd, rl, exp_cyc, exp_nout, exp_noe;
        logic [1:0]        exp_err;
        logic [ADDR_W-1:0] wb, rb;
        logic [DATA_W-1:0] exp_o[$];
        logic [DATA_W-1:0] exp_x;
        for (int k = 0; k < 10; k++) begin
            wb  = (k == 0) ? 14'h3FFE : ADDR_W'($urandom);
            rb  = (k == 1) ? 14'h3FFF : ADDR_W'($urandom);
            wrc = (k == 0) ? 5 : $urandom_range(0, 5);
            rdc = (k == 1) ? 3 : $urandom_range(0, 4);
            dd  = $urandom_range(0, 12);
            rl  = $urandom_range(0, 4);
            wdat_q = {};
            for (int i = 0; i < wrc; i++) wdat_q.push_back(DATA_W'($urandom));
            exp_o = {};
            exp_x = '0;
            for (int j = 0; j < rdc; j++) begin
                exp_o.push_back(DATA_W'($urandom));
                rd_mem[rb + ADDR_W'(j)] = exp_o[j];
                exp_x ^= exp_o[j];
            end
            model_job(dd, rl, rdc, exp_cyc, exp_err, exp_nout, exp_noe);
            run_job(wb, rb, wrc, rdc, dd, rl, $urandom_range(40, 100), 1'b0, 1'b0, ok);
            n_total++; if (!ok) begin
                n_bad++; $display("FAIL rnd%0d_finish got=timeout exp=done", k); end
            n_total++; if (wa_q.size() != wrc) begin
                n_bad++; $display("FAIL rnd%0d_nwr got=%0d exp=%0d", k, wa_q.size(), wrc); end
            for (int i = 0; i < wrc && i < wa_q.size(); i++) begin
                n_total++;
                if (wa_q[i] !== wb + ADDR_W'(i) || wd_q[i] !== wdat_q[i]) begin
                    n_bad++; $display("FAIL rnd%0d_wr%0d got=%h:%h exp=%h:%h", k, i, wa_q[i],
                                      wd_q[i], wb + ADDR_W'(i), wdat_q[i]); end
            end
            n_total++;
            if (start_cnt != 1 ||
                start_cyc != ((wrc > 0) ? last_we_cyc + 1 : go_cyc + 1)) begin
                n_bad++; $display("FAIL rnd%0d_start got=cnt%0d@%0d exp=cnt1", k, start_cnt,
                                  start_cyc); end
            n_total++; if (cyc_count !== 32'(exp_cyc) || err !== exp_err) begin
                n_bad++; $display("FAIL rnd%0d_cyc got=%0d/%b exp=%0d/%b", k, cyc_count, err,
                                  exp_cyc, exp_err); end
            n_total++; if (od_q.size() != exp_nout || oe_cnt != exp_noe) begin
                n_bad++; $display("FAIL rnd%0d_nrd got=out%0d oe%0d exp=out%0d oe%0d", k,
                                  od_q.size(), oe_cnt, exp_nout, exp_noe); end
            for (int j = 0; j < exp_nout && j < od_q.size(); j++) begin
                n_total++;
                if (od_q[j] !== exp_o[j] || oa_q[j] !== rb + ADDR_W'(j)) begin
                    n_bad++; $display("FAIL rnd%0d_rd%0d got=%h@%h exp=%h@%h", k, j, od_q[j],
                                      oa_q[j], exp_o[j], rb + ADDR_W'(j)); end
            end
            n_total++; if (stab_bad != 0 || size_bad != 0 || fin_cnt != 1) begin
                n_bad++; $display("FAIL rnd%0d_misc got=unstable%0d size%0d fin%0d exp=0/0/1",
                                  k, stab_bad, size_bad, fin_cnt); end
`ifdef LAUNCHER_CHECKSUM_EN
            n_total++; if (checksum !== exp_x) begin
                n_bad++; $display("FAIL rnd%0d_chk got=%h exp=%h", k, checksum, exp_x); end
`endif
        end
    endtask

    task automatic test_cfg_go_busy();
        bit ok;
        wdat_q = '{8'hC1, 8'hC2, 8'hC3};
        rd_mem[14'h080] = 8'h3C;
        rd_mem[14'h081] = 8'hC3;
        run_job(14'h070, 14'h080, 3, 2, 12, 2, 70, 1'b0, 1'b1, ok);
        n_total++; if (!ok) begin n_bad++; $display("FAIL gobusy_finish got=timeout exp=done"); end
        n_total++; if (wa_q.size() != 3 || start_cnt != 1) begin
            n_bad++; $display("FAIL gobusy_job got=wr%0d start%0d exp=wr3 start1", wa_q.size(),
                              start_cnt); end
        n_total++; if (cyc_count !== 32'd13 || od_q.size() != 2) begin
            n_bad++; $display("FAIL gobusy_res got=cyc%0d out%0d exp=cyc13 out2", cyc_count,
                              od_q.size()); end
        repeat (2) @(negedge clock);
        n_total++; if (busy !== 1'b0) begin
            n_bad++; $display("FAIL gobusy_idle got=busy%0b exp=busy0", busy); end
    endtask

    task automatic test_spurious_done();
        @(negedge clock);
        spur_done = 1'b1;
        repeat (3) @(negedge clock);
        spur_done = 1'b0;
        @(negedge clock);
        n_total++; if (busy !== 1'b0 || cyc_count !== 32'd13 || start_port !== 1'b0) begin
            n_bad++; $display("FAIL spurdone got=busy%0b cyc%0d exp=busy0 cyc13", busy,
                              cyc_count); end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        @(negedge clock);
        done_delay = -1; rd_lat = 0;
        cfg_wr_count = 16'd0; cfg_rd_count = 16'd1; cfg_go = 1'b1; mon_clr = 1'b1;
        @(negedge clock);
        cfg_go = 1'b0; mon_clr = 1'b0;
        repeat (4) @(negedge clock);
        n_total++; if (busy !== 1'b1) begin
            n_bad++; $display("FAIL midrst_running got=busy%0b exp=busy1", busy); end
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        n_total++; if ({busy, start_port, S_oe_ram, S_we_ram, out_valid, finished} !== 6'b0) begin
            n_bad++; $display("FAIL midrst_ctrl got=%b exp=000000",
                              {busy, start_port, S_oe_ram, S_we_ram, out_valid, finished}); end
        n_total++; if (cyc_count !== 32'd0 || err !== 2'b00 || S_data_ram_size !== 8'd0) begin
            n_bad++; $display("FAIL midrst_status got=%0d/%b/%0d exp=0/00/0", cyc_count, err,
                              S_data_ram_size); end
        @(negedge clock);
        reset = 1'b1;
        wdat_q = {};
        run_job(14'h000, 14'h000, 0, 0, 3, 0, 100, 1'b0, 1'b0, ok);
        n_total++; if (!ok) begin n_bad++; $display("FAIL midrst_finish got=timeout exp=done"); end
        n_total++; if (start_cnt != 1 || start_cyc != go_cyc + 1) begin
            n_bad++; $display("FAIL midrst_start got=cnt%0d exp=cnt1 right after go", start_cnt);
        end
        n_total++; if (fin_cyc != start_cyc + 4 || cyc_count !== 32'd4 || oe_cnt != 0) begin
            n_bad++; $display("FAIL midrst_fin got=+%0d cyc%0d oe%0d exp=+4 cyc4 oe0",
                              fin_cyc - start_cyc, cyc_count, oe_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drain_stall();
        test_run_timeout();
        test_read_timeout();
        test_random_jobs();
        test_cfg_go_busy();
        test_spurious_done();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=still running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
